// File: rtl/param_ring_counter.sv
// param_ring_counter
//   Parametrised one-hot ring / Johnson (twisted-ring) shift counter used as a sequencer or
//   phase generator. Supports enable, direction control, parallel load, a wrap pulse once per
//   period and self-correction of illegal states back to INIT.
//
// Parameters
//   WIDTH    number of state bits (>= 2)
//   INIT     reset pattern; must be legal for the selected mode
//   JOHNSON  0 = one-hot ring, 1 = Johnson
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset (out <= INIT, wrap/fault cleared)
//   en        advance one step this cycle
//   dir       0 = shift toward MSB, 1 = shift toward LSB
//   load      load load_val verbatim this cycle (wins over en)
//   load_val  parallel load pattern
//   out       current state (registered)
//   wrap      1-cycle pulse: the step just taken completed a full period
//   fault     1-cycle pulse: an illegal state was replaced by INIT
module param_ring_counter #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] INIT    = 'd1,
   parameter bit               JOHNSON = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             fault
);

   localparam logic [WIDTH-1:0] One     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MsbOnly = One << (WIDTH - 1);
   localparam logic [WIDTH-2:0] DiffOne = (WIDTH - 1)'(1);

   logic [WIDTH-1:0] state_q, state_d;
   logic             wrap_q, wrap_d;
   logic             fault_q, fault_d;

   logic [WIDTH-2:0] diff;
   logic             ring_legal;
   logic             johnson_legal;
   logic             legal;

   // Ring: exactly one bit set. Johnson: at most one boundary between adjacent bits.
   always_comb begin
      diff          = state_q[WIDTH-2:0] ^ state_q[WIDTH-1:1];
      ring_legal    = (state_q != '0) && ((state_q & (state_q - One)) == '0);
      johnson_legal = ((diff & (diff - DiffOne)) == '0);
      legal         = JOHNSON ? johnson_legal : ring_legal;
   end

   always_comb begin
      state_d = state_q;
      wrap_d  = 1'b0;
      fault_d = 1'b0;
      if (load) begin
         state_d = load_val;
      end else if (en) begin
         if (!legal) begin
            // Correcting step: no shift this cycle, just return to a known-good pattern.
            state_d = INIT;
            fault_d = 1'b1;
         end else if (JOHNSON) begin
            if (dir) begin
               state_d = {~state_q[0], state_q[WIDTH-1:1]};
               wrap_d  = (state_q == One);
            end else begin
               state_d = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
               wrap_d  = (state_q == MsbOnly);
            end
         end else begin
            if (dir) begin
               state_d = {state_q[0], state_q[WIDTH-1:1]};
               wrap_d  = state_q[0];
            end else begin
               state_d = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
               wrap_d  = state_q[WIDTH-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         wrap_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wrap_q  <= wrap_d;
         fault_q <= fault_d;
      end
   end

   assign out   = state_q;
   assign wrap  = wrap_q;
   assign fault = fault_q;

endmodule
